// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the serializer sequencer/arbiter.
package shift_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned GAP_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Two-way round-robin pick: a lone requester wins, ties go to ptr.
  function automatic logic arb_pick(input logic [1:0] valid, input logic ptr);
    logic pick;
    pick = ptr;
    case (valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ptr;
      default: pick = ptr;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/shift_seq_arbiter_if.sv
// Requester handshake and serial output bundle of the serializer.
interface shift_seq_arbiter_if
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             owner;
  logic             done;

  // Producer side: offers words, observes grants and the serial stream.
  modport master (
    output req_valid,
    output req_data0,
    output req_data1,
    input  req_ready,
    input  ser_out,
    input  ser_valid,
    input  owner,
    input  done
  );

  // Sequencer side.
  modport slave (
    input  req_valid,
    input  req_data0,
    input  req_data1,
    output req_ready,
    output ser_out,
    output ser_valid,
    output owner,
    output done
  );

endinterface

// File: rtl/shift_core.sv
// WIDTH-bit left-shift register with parallel load; load wins over shift.
module shift_core
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  // Load a new word or shift left with zero fill; a full frame leaves sr at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/shift_seq_arbiter.sv
// Round-robin two-port arbiter sequencing load + WIDTH shifts per frame.
module shift_seq_arbiter
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  shift_seq_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]     LAST_BIT     = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     PRE_LAST_BIT = CNT_W'(WIDTH - 2);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP     = GAP_CNT_W'(GAP - 1);

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 ptr;
  logic                 owner_q;
  logic                 ser_valid_q;
  logic                 done_q;

  logic                 winner;
  logic [1:0]           ready_c;
  logic                 xfer;
  logic [WIDTH-1:0]     win_data;
  logic                 msb;

  // Grant only the arbitration winner, only in IDLE and never during reset.
  always_comb begin
    winner  = arb_pick(bus.req_valid, ptr);
    ready_c = 2'b00;
    if (state == IDLE && !rst) begin
      ready_c[winner] = bus.req_valid[winner];
    end
  end

  assign xfer     = |(ready_c & bus.req_valid);
  assign win_data = winner ? bus.req_data1 : bus.req_data0;

  // Sequencer FSM with bit/gap counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ptr         <= 1'b0;
      owner_q     <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state       <= SHIFT;
            bit_cnt     <= '0;
            owner_q     <= winner;
            ptr         <= ~winner;
            ser_valid_q <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            gap_cnt     <= '0;
            state       <= (GAP > 0) ? PAUSE : IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            // done lines up with the cycle that presents the last bit
            done_q  <= (bit_cnt == PRE_LAST_BIT);
          end
        end
        PAUSE: begin
          if (gap_cnt == LAST_GAP) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .load_data (win_data),
    .shift     (state == SHIFT),
    .msb       (msb)
  );

  // The register drains to zero after a frame, so msb is already 0 when idle.
  assign bus.req_ready = ready_c;
  assign bus.ser_out   = msb;
  assign bus.ser_valid = ser_valid_q;
  assign bus.owner     = owner_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// Directed bench for shift_seq_arbiter: GAP=1 main instance plus a GAP=0 instance.
module tb_shift_seq_arbiter;
  import shift_seq_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  shift_seq_arbiter_if #(.WIDTH(WIDTH)) bus ();
  shift_seq_arbiter_if #(.WIDTH(WIDTH)) bus_g0 ();

  shift_seq_arbiter #(.WIDTH(WIDTH), .GAP(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  shift_seq_arbiter #(.WIDTH(WIDTH), .GAP(0)) u_dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (bus_g0.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;    bus.req_data0 = '0;    bus.req_data1 = '0;
    bus_g0.req_valid = 2'b00; bus_g0.req_data0 = '0; bus_g0.req_data1 = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11; bus.req_data0 = 8'h11; bus.req_data1 = 8'h22;
    step();
    step();
    checks++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
    checks++; if (bus.ser_out !== 1'b0) begin fails++; $display("FAIL reset_ser_out: got %b want 0", bus.ser_out); end
    checks++; if (bus.ser_valid !== 1'b0) begin fails++; $display("FAIL reset_ser_valid: got %b want 0", bus.ser_valid); end
    checks++; if (bus.owner !== 1'b0) begin fails++; $display("FAIL reset_owner: got %b want 0", bus.owner); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL reset_first_grant: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    checks++; if (bus.owner !== 1'b0) begin fails++; $display("FAIL reset_first_owner: got %b want 0", bus.owner); end
    checks++; if (bus.ser_valid !== 1'b1) begin fails++; $display("FAIL reset_first_valid: got %b want 1", bus.ser_valid); end
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    w = 8'hA5;
    apply_reset();
    bus.req_data0 = w; bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL single_grant: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00; bus.req_data0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.ser_valid !== 1'b1) begin fails++; $display("FAIL single_valid[%0d]: got %b want 1", i, bus.ser_valid); end
      checks++; if (bus.ser_out !== w[7-i]) begin fails++; $display("FAIL single_bit[%0d]: got %b want %b", i, bus.ser_out, w[7-i]); end
      checks++; if (bus.done !== (i == 7)) begin fails++; $display("FAIL single_done[%0d]: got %b want %b", i, bus.done, (i == 7)); end
      checks++; if (bus.owner !== 1'b0) begin fails++; $display("FAIL single_owner[%0d]: got %b want 0", i, bus.owner); end
      checks++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL single_busy_ready[%0d]: got %b want 00", i, bus.req_ready); end
      step();
    end
    bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL single_pause_ready: got %b want 00", bus.req_ready); end
    checks++; if (bus.ser_valid !== 1'b0) begin fails++; $display("FAIL single_pause_valid: got %b want 0", bus.ser_valid); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL single_pause_done: got %b want 0", bus.done); end
    step();
    checks++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL single_ready_t10: got %b want 01", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_contention();
    logic [7:0] words [3];
    logic       owns  [3];
    logic [7:0] got;
    words = '{8'h81, 8'h7E, 8'h81};
    owns  = '{1'b0, 1'b1, 1'b0};
    apply_reset();
    bus.req_data0 = 8'h81; bus.req_data1 = 8'h7E; bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.req_ready !== (owns[k] ? 2'b10 : 2'b01)) begin fails++; $display("FAIL contend_grant[%0d]: got %b want %b", k, bus.req_ready, (owns[k] ? 2'b10 : 2'b01)); end
      step();
      if (k == 2) bus.req_valid = 2'b00;
      got = '0;
      for (int i = 0; i < 8; i++) begin
        got = {got[6:0], bus.ser_out};
        step();
      end
      checks++; if (got !== words[k]) begin fails++; $display("FAIL contend_word[%0d]: got %h want %h", k, got, words[k]); end
      checks++; if (bus.owner !== owns[k]) begin fails++; $display("FAIL contend_owner[%0d]: got %b want %b", k, bus.owner, owns[k]); end
      checks++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL contend_pause_ready[%0d]: got %b want 00", k, bus.req_ready); end
      step();
    end
  endtask

  task automatic test_lone_requester();
    logic [7:0] words [3];
    logic [7:0] got;
    words = '{8'h3C, 8'hC3, 8'h5A};
    apply_reset();
    bus.req_data1 = words[0]; bus.req_valid = 2'b10;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL lone_grant[%0d]: got %b want 10", k, bus.req_ready); end
      step();
      if (k < 2) bus.req_data1 = words[k+1];
      else bus.req_valid = 2'b00;
      got = '0;
      for (int i = 0; i < 8; i++) begin
        got = {got[6:0], bus.ser_out};
        step();
      end
      checks++; if (got !== words[k]) begin fails++; $display("FAIL lone_word[%0d]: got %h want %h", k, got, words[k]); end
      checks++; if (bus.owner !== 1'b1) begin fails++; $display("FAIL lone_owner[%0d]: got %b want 1", k, bus.owner); end
      step();
    end
    bus.req_valid = 2'b11; bus.req_data0 = 8'h01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL lone_then_both: got %b want 01", bus.req_ready); end
    bus.req_valid = 2'b00;
    #1;
  endtask

  task automatic test_gap0();
    logic [7:0] got;
    apply_reset();
    bus_g0.req_data0 = 8'h96; bus_g0.req_valid = 2'b01;
    #1;
    checks++; if (bus_g0.req_ready !== 2'b01) begin fails++; $display("FAIL gap0_grant0: got %b want 01", bus_g0.req_ready); end
    step();
    bus_g0.req_data0 = 8'h69;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], bus_g0.ser_out};
      if (i == 7) begin
        checks++; if (bus_g0.done !== 1'b1) begin fails++; $display("FAIL gap0_done: got %b want 1", bus_g0.done); end
      end
      step();
    end
    checks++; if (got !== 8'h96) begin fails++; $display("FAIL gap0_word0: got %h want 96", got); end
    checks++; if (bus_g0.ser_valid !== 1'b0) begin fails++; $display("FAIL gap0_idle_valid: got %b want 0", bus_g0.ser_valid); end
    checks++; if (bus_g0.req_ready !== 2'b01) begin fails++; $display("FAIL gap0_grant1: got %b want 01", bus_g0.req_ready); end
    step();
    bus_g0.req_valid = 2'b00;
    checks++; if (bus_g0.ser_valid !== 1'b1) begin fails++; $display("FAIL gap0_second_start: got %b want 1", bus_g0.ser_valid); end
    got = '0;
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], bus_g0.ser_out};
      step();
    end
    checks++; if (got !== 8'h69) begin fails++; $display("FAIL gap0_word1: got %h want 69", got); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    apply_reset();
    bus.req_data0 = 8'hFF; bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    step();
    step();
    step();
    checks++; if (bus.ser_out !== 1'b1) begin fails++; $display("FAIL mid_bit4_before: got %b want 1", bus.ser_out); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.ser_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", bus.ser_valid); end
    checks++; if (bus.ser_out !== 1'b0) begin fails++; $display("FAIL mid_ser_out: got %b want 0", bus.ser_out); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL mid_done: got %b want 0", bus.done); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({bus.ser_valid, bus.done, bus.ser_out} !== 3'b000) begin fails++; $display("FAIL mid_quiet[%0d]: got %b want 000", i, {bus.ser_valid, bus.done, bus.ser_out}); end
    end
    bus.req_data0 = 8'h12; bus.req_data1 = 8'h34; bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL mid_after_grant: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], bus.ser_out};
      step();
    end
    checks++; if (got !== 8'h12) begin fails++; $display("FAIL mid_after_word: got %h want 12", got); end
    checks++; if (bus.owner !== 1'b0) begin fails++; $display("FAIL mid_after_owner: got %b want 0", bus.owner); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;    bus.req_data0 = '0;    bus.req_data1 = '0;
    bus_g0.req_valid = 2'b00; bus_g0.req_data0 = '0; bus_g0.req_data1 = '0;
    test_reset();
    test_single_frame();
    test_contention();
    test_lone_requester();
    test_gap0();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got still running want finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
